// File: rtl/key_mac_accumulate.sv
// key_mac_accumulate: 4-digit x 2-key pointwise modular MAC, 4-stage pipeline.
// Define KEY_MAC_ACCUMULATE_EN to add a prior accumulator (acc_in) into each result.
module key_mac_accumulate #(
    parameter int          W  = 27,
    parameter int unsigned Q  = 134215681,
    parameter int          P  = 16,
    parameter int          N  = 1024,
    parameter int          CW = $clog2(N / P)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [4*P*W-1:0] digit_in,
    input  logic [8*P*W-1:0] key_in,
`ifdef KEY_MAC_ACCUMULATE_EN
    input  logic [2*P*W-1:0] acc_in,
`endif
    output logic             busy,
    output logic             out_valid,
    output logic [CW-1:0]    out_index,
    output logic [P*W-1:0]   acc0_out,
    output logic [P*W-1:0]   acc1_out,
    output logic             done
);

    localparam int PRW = 2 * W;
    localparam int XW  = 2 * W + 2;
    localparam int XW1 = XW + 1;
    localparam int BW  = XW + XW1;
    localparam int RW  = W + 1;
    localparam logic [CW-1:0] LAST = CW'(N / P - 1);
    localparam logic [XW:0] QX1 = XW1'(Q);
    localparam logic [RW-1:0] QR = RW'(Q);
    // Barrett constant: floor(2^XW / Q) keeps the quotient estimate within one of exact
    localparam logic [XW:0] MU = {1'b1, {XW{1'b0}}} / QX1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state_q, state_d;
    logic busy_q, busy_d, done_q, done_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] out_idx_q, out_idx_d;
    logic accept;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic [4*P*W-1:0] dig1_q, dig1_d;
    logic [8*P*W-1:0] key1_q, key1_d;
    logic [2*P*W-1:0] acc_s;
    logic [2*P*W-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
    logic [8*P-1:0][PRW-1:0] prod2_q, prod2_d;
    logic [2*P-1:0][RW-1:0] red3_q, red3_d;
    logic [P*W-1:0] res0_q, res0_d, res1_q, res1_d;

    logic [XW-1:0] x;
    logic [BW-1:0] bprod;
    logic [XW:0] qhat;
    logic [RW-1:0] r4;

`ifdef KEY_MAC_ACCUMULATE_EN
    assign acc_s = acc_in;
`else
    assign acc_s = '0;
`endif

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // a start coinciding with done is dropped
                if (start && !done_q) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    in_cnt_d = in_cnt_q + CW'(1);
                    if (in_cnt_q == LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (v4_q && !v1_q && !v2_q && !v3_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (v3_q) out_cnt_d = out_cnt_q + CW'(1);
    end

    always_comb begin
        v1_d   = accept;
        dig1_d = dig1_q;
        key1_d = key1_q;
        acc1_d = acc1_q;
        if (accept) begin
            dig1_d = digit_in;
            key1_d = key_in;
            acc1_d = acc_s;
        end
    end

    always_comb begin
        v2_d    = v1_q;
        prod2_d = prod2_q;
        acc2_d  = acc2_q;
        if (v1_q) begin
            acc2_d = acc1_q;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 2; j++) begin
                    for (int l = 0; l < P; l++) begin
                        prod2_d[(i*2+j)*P+l] =
                            PRW'(dig1_q[(i*P+l)*W +: W]) *
                            PRW'(key1_q[((i*2+j)*P+l)*W +: W]);
                    end
                end
            end
        end
    end

    always_comb begin
        v3_d   = v2_q;
        red3_d = red3_q;
        x      = '0;
        bprod  = '0;
        qhat   = '0;
        if (v2_q) begin
            for (int j = 0; j < 2; j++) begin
                for (int l = 0; l < P; l++) begin
                    x = XW'(acc2_q[(j*P+l)*W +: W]);
                    for (int i = 0; i < 4; i++) begin
                        x = x + XW'(prod2_q[(i*2+j)*P+l]);
                    end
                    bprod = BW'(x) * BW'(MU);
                    qhat  = XW1'(bprod >> XW);
                    // remainder lies in [0, 2Q), so it fits in W+1 bits
                    red3_d[j*P+l] = RW'(XW1'(x) - qhat * QX1);
                end
            end
        end
    end

    always_comb begin
        v4_d      = v3_q;
        res0_d    = res0_q;
        res1_d    = res1_q;
        out_idx_d = out_idx_q;
        r4        = '0;
        if (v3_q) begin
            out_idx_d = out_cnt_q;
            for (int l = 0; l < P; l++) begin
                r4 = red3_q[l];
                r4 = (r4 >= QR) ? r4 - QR : r4;
                res0_d[l*W +: W] = W'(r4);
                r4 = red3_q[P+l];
                r4 = (r4 >= QR) ? r4 - QR : r4;
                res1_d[l*W +: W] = W'(r4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            out_idx_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            v4_q      <= 1'b0;
            dig1_q    <= '0;
            key1_q    <= '0;
            acc1_q    <= '0;
            acc2_q    <= '0;
            prod2_q   <= '0;
            red3_q    <= '0;
            res0_q    <= '0;
            res1_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            out_idx_q <= out_idx_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            v4_q      <= v4_d;
            dig1_q    <= dig1_d;
            key1_q    <= key1_d;
            acc1_q    <= acc1_d;
            acc2_q    <= acc2_d;
            prod2_q   <= prod2_d;
            red3_q    <= red3_d;
            res0_q    <= res0_d;
            res1_q    <= res1_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = v4_q;
    assign out_index = out_idx_q;
    assign acc0_out  = res0_q;
    assign acc1_out  = res1_q;

endmodule

// File: tb/tb_key_mac_accumulate.sv
// Scoreboard bench for key_mac_accumulate: expected beats are queued at drive
// time and compared, with their latency, when out_valid appears.
module tb_key_mac_accumulate;

    localparam int          W     = 27;
    localparam int unsigned Q     = 134215681;
    localparam int          P     = 16;
    localparam int          N     = 1024;
    localparam int          BEATS = N / P;
    localparam int          CW    = $clog2(BEATS);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic [4*P*W-1:0] digit_in;
    logic [8*P*W-1:0] key_in;
    logic [2*P*W-1:0] acc_v;
    logic             busy;
    logic             out_valid;
    logic [CW-1:0]    out_index;
    logic [P*W-1:0]   acc0_out;
    logic [P*W-1:0]   acc1_out;
    logic             done;

    typedef struct {
        int             cyc;
        logic [CW-1:0]  idx;
        logic [P*W-1:0] r0;
        logic [P*W-1:0] r1;
        bit             last;
    } ent_t;

    ent_t sb[$];
    ent_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_done = -1;
    int   ndone = 0;
    int   exp_ndone = 0;
    bit   armed = 1'b0;
    int   nacc = 0;

    key_mac_accumulate #(.W(W), .Q(Q), .P(P), .N(N), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .digit_in  (digit_in),
        .key_in    (key_in),
`ifdef KEY_MAC_ACCUMULATE_EN
        .acc_in    (acc_v),
`endif
        .busy      (busy),
        .out_valid (out_valid),
        .out_index (out_index),
        .acc0_out  (acc0_out),
        .acc1_out  (acc1_out),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [P*W-1:0] got,
                         input logic [P*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [P*W-1:0] model(input logic [4*P*W-1:0] d,
                                             input logic [8*P*W-1:0] k,
                                             input logic [2*P*W-1:0] a,
                                             input int j);
        logic [P*W-1:0] r;
        longint unsigned s;
        r = '0;
        for (int l = 0; l < P; l++) begin
            s = 64'(a[(j*P+l)*W +: W]);
            for (int i = 0; i < 4; i++)
                s += 64'(d[(i*P+l)*W +: W]) * 64'(k[((i*2+j)*P+l)*W +: W]);
            r[l*W +: W] = W'(s % 64'(Q));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4*P*W-1:0] d, input logic [8*P*W-1:0] k,
                        input logic [2*P*W-1:0] a);
        ent_t e;
        digit_in = d;
        key_in   = k;
        acc_v    = a;
        in_valid = 1'b1;
        if (armed) begin
            e.cyc  = cyc;
            e.idx  = CW'(nacc);
            e.r0   = model(d, k, a, 0);
            e.r1   = model(d, k, a, 1);
            e.last = (nacc == BEATS - 1);
            sb.push_back(e);
            nacc++;
            if (nacc == BEATS) begin
                armed = 1'b0;
                exp_ndone++;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        armed = 1'b1;
        nacc  = 0;
    endtask

    task automatic rnd(output logic [4*P*W-1:0] d, output logic [8*P*W-1:0] k,
                       output logic [2*P*W-1:0] a);
        d = '0;
        k = '0;
        a = '0;
        for (int l = 0; l < 4 * P; l++) d[l*W +: W] = W'($urandom_range(0, Q - 1));
        for (int l = 0; l < 8 * P; l++) k[l*W +: W] = W'($urandom_range(0, Q - 1));
`ifdef KEY_MAC_ACCUMULATE_EN
        for (int l = 0; l < 2 * P; l++) a[l*W +: W] = W'($urandom_range(0, Q - 1));
`endif
    endtask

    task automatic bl(input int b, output logic [4*P*W-1:0] d,
                      output logic [8*P*W-1:0] k);
        d = '0;
        k = '0;
        for (int l = 0; l < P; l++) begin
            d[l*W +: W] = W'(b);
            k[l*W +: W] = W'(l);
        end
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while ((busy || sb.size() != 0) && i < 400) begin
            tick();
            i++;
        end
        check("drain_timeout", 1'(i < 400), 1'b1);
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("ov_extra", out_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("latency", cyc - mon_e.cyc, 4);
                    check("out_index", out_index, mon_e.idx);
                    check("acc0", acc0_out, mon_e.r0);
                    check("acc1", acc1_out, mon_e.r1);
                    if (mon_e.last) exp_done = cyc + 1;
                end
            end
            if (cyc == exp_done) begin
                check("done", done, 1'b1);
                check("busy_fall", busy, 1'b0);
                ndone++;
            end else if (done) begin
                check("done_extra", done, 1'b0);
            end
        end
    end

    initial begin
        logic [4*P*W-1:0] d;
        logic [8*P*W-1:0] k;
        logic [2*P*W-1:0] a;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        digit_in = '0;
        key_in   = '0;
        acc_v    = '0;
        repeat (2) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_ov", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_idx", out_index, '0);
        check("rst_acc0", acc0_out, '0);
        check("rst_acc1", acc1_out, '0);
        reset = 1'b0;
        tick();

        // in_valid while idle
        for (int b = 0; b < 3; b++) begin
            rnd(d, k, a);
            beat(d, k, a);
        end
        repeat (6) tick();

        // run A: basic, worst case, random, restart mid-run, extra beats
        do_start();
        d = '0;
        k = '0;
        a = '0;
        d[0 +: W] = W'(1);
        k[0 +: W] = W'(5);
        k[P*W +: W] = W'(7);
        beat(d, k, a);
        for (int l = 0; l < 4 * P; l++) d[l*W +: W] = W'(Q - 1);
        for (int l = 0; l < 8 * P; l++) k[l*W +: W] = W'(Q - 1);
`ifdef KEY_MAC_ACCUMULATE_EN
        for (int l = 0; l < 2 * P; l++) a[l*W +: W] = W'(Q - 1);
`endif
        beat(d, k, a);
        for (int b = 2; b < BEATS; b++) begin
            rnd(d, k, a);
            if (b == 30) start = 1'b1;
            beat(d, k, a);
            start = 1'b0;
        end
        for (int b = 0; b < 3; b++) begin
            rnd(d, k, a);
            beat(d, k, a);
        end
        wait_done();

        // run B: full polynomial contiguous, then start on the done cycle
        do_start();
        a = '0;
        for (int b = 0; b < BEATS; b++) begin
            bl(b, d, k);
            beat(d, k, a);
        end
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        check("done_seen", done, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rnd(d, k, a);
            beat(d, k, a);
        end
        check("start_on_done", busy, 1'b0);
        repeat (8) tick();

        // run C: same data, gapped
        do_start();
        a = '0;
        for (int b = 0; b < BEATS; b++) begin
            bl(b, d, k);
            beat(d, k, a);
            tick();
        end
        wait_done();

        // run D: reset mid-run
        do_start();
        for (int b = 0; b < 10; b++) begin
            rnd(d, k, a);
            beat(d, k, a);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ov", out_valid, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_idx", out_index, '0);
        check("mid_rst_acc0", acc0_out, '0);
        check("mid_rst_acc1", acc1_out, '0);
        sb.delete();
        exp_done = -1;
        armed = 1'b0;
        tick();
        reset = 1'b0;
        repeat (10) tick();

        // run E: fresh random polynomial after reset
        do_start();
        for (int b = 0; b < BEATS; b++) begin
            rnd(d, k, a);
            beat(d, k, a);
        end
        wait_done();

        check("done_count", ndone, exp_ndone);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
